// File: rtl/qif_pkg.sv
// Shared definitions for the QIF neuron voltage readout: detector state
// encoding, default thresholds/window sizes and a saturating increment.
package qif_pkg;

    localparam int VW = 8;

    localparam logic [VW-1:0] V_TH_DEFAULT   = 8'd200;
    localparam logic [VW-1:0] V_HYST_DEFAULT = 8'd16;
    localparam int            WIN_LOG2_DEFAULT = 10;
    localparam int            ISI_W_DEFAULT    = 16;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } qif_state_e;

    // Add one to an 8-bit count when enabled, sticking at all-ones.
    function automatic logic [VW-1:0] sat_inc(input logic [VW-1:0] x, input logic en);
        if (en && (x != '1)) begin
            return x + VW'(1);
        end
        return x;
    endfunction

endpackage

// File: rtl/qif_spike_detect.sv
// Threshold/hysteresis spike detector for the QIF membrane voltage.
// `spike` is the registered one-cycle pulse; `fire` is the same decision
// one cycle earlier so downstream logic can align with the pulse.
module qif_spike_detect
    import qif_pkg::*;
#(
    parameter logic [VW-1:0] V_TH   = V_TH_DEFAULT,
    parameter logic [VW-1:0] V_HYST = V_HYST_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [VW-1:0] v_in,
    output logic          spike,
    output logic          fire
);

    localparam logic [VW-1:0] V_REARM = V_TH - V_HYST;

    generate
        if (V_HYST > V_TH) begin : g_bad_hyst
            $error("qif_spike_detect: V_HYST must not exceed V_TH");
        end
    endgenerate

    qif_state_e state;
    logic       below_rearm;

    // Threshold crossing is only honoured while armed; rearm level is shared.
    always_comb begin
        below_rearm = (v_in <= V_REARM);
        fire        = (state == ARMED) && (v_in >= V_TH);
    end

    // Detector FSM: INIT waits for a low voltage, ARMED fires once, FIRED waits to rearm.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            spike <= 1'b0;
        end else begin
            spike <= fire;
            case (state)
                INIT: begin
                    if (below_rearm) state <= ARMED;
                end
                ARMED: begin
                    if (fire) state <= FIRED;
                end
                FIRED: begin
                    if (below_rearm) state <= ARMED;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: rtl/qif_spike_decoder.sv
// QIF spike decoder top: spike detection, per-window spike rate and
// inter-spike interval. Define QIF_DECODER_ISI_EN to build the ISI logic;
// without it `isi` and `isi_valid` are tied low.
module qif_spike_decoder
    import qif_pkg::*;
#(
    parameter logic [VW-1:0] V_TH     = V_TH_DEFAULT,
    parameter logic [VW-1:0] V_HYST   = V_HYST_DEFAULT,
    parameter int            WIN_LOG2 = WIN_LOG2_DEFAULT,
    parameter int            ISI_W    = ISI_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VW-1:0]    v_in,
    output logic             spike,
    output logic [7:0]       rate,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid
);

    generate
        if ((WIN_LOG2 < 4) || (WIN_LOG2 > 16)) begin : g_bad_win
            $error("qif_spike_decoder: WIN_LOG2 must be within 4..16");
        end
        if (ISI_W < 1) begin : g_bad_isi
            $error("qif_spike_decoder: ISI_W must be at least 1");
        end
    endgenerate

    logic                fire;
    logic [WIN_LOG2-1:0] wcnt;
    logic [7:0]          scnt;
    logic                wterm;

    qif_spike_detect #(
        .V_TH   (V_TH),
        .V_HYST (V_HYST)
    ) u_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .v_in  (v_in),
        .spike (spike),
        .fire  (fire)
    );

    assign wterm = &wcnt;

    // Rate window: a spike pulse in the terminal cycle still belongs to the closing window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt       <= '0;
            scnt       <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            wcnt       <= wcnt + WIN_LOG2'(1);
            rate_valid <= wterm;
            if (wterm) begin
                rate <= sat_inc(scnt, spike);
                scnt <= '0;
            end else begin
                scnt <= sat_inc(scnt, spike);
            end
        end
    end

`ifdef QIF_DECODER_ISI_EN
    logic [ISI_W-1:0] icnt;
    logic             seen;

    // ISI runs off the detector decision so isi_valid lines up with the spike pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icnt      <= '0;
            seen      <= 1'b0;
            isi       <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= fire && seen;
            if (fire) begin
                icnt <= ISI_W'(1);
                seen <= 1'b1;
                if (seen) isi <= icnt;
            end else if (!(&icnt)) begin
                icnt <= icnt + ISI_W'(1);
            end
        end
    end
`else
    logic unused_fire;

    assign unused_fire = fire;
    assign isi         = '0;
    assign isi_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Directed bench for qif_spike_decoder. Two instances share the stimulus:
// d0 with a 16-cycle window, d1 with a 1024-cycle window and 4-bit ISI.
module tb_qif_spike_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  v_in;

    logic        spike0, rate_valid0, isi_valid0;
    logic [7:0]  rate0;
    logic [15:0] isi0;
    logic        spike1, rate_valid1, isi_valid1;
    logic [7:0]  rate1;
    logic [3:0]  isi1;

    int compared;
    int mismatched;
    int t;
    int rate_tab [5];

    qif_spike_decoder #(.WIN_LOG2(4), .ISI_W(16)) d0 (
        .clk(clk), .rst_n(rst_n), .v_in(v_in), .spike(spike0), .rate(rate0),
        .rate_valid(rate_valid0), .isi(isi0), .isi_valid(isi_valid0)
    );

    qif_spike_decoder #(.WIN_LOG2(10), .ISI_W(4)) d1 (
        .clk(clk), .rst_n(rst_n), .v_in(v_in), .spike(spike1), .rate(rate1),
        .rate_valid(rate_valid1), .isi(isi1), .isi_valid(isi_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    // One clock edge with v_in applied; t counts edges since reset release.
    task automatic applyStimulus(input logic [7:0] v);
        int w;
        v_in = v;
        @(posedge clk);
        #1;
        if (rst_n) begin
            t++;
            w = t / 16;
            if (w > 4) w = 4;
            checkOutput("rate_valid0", rate_valid0, (t % 16) == 15);
            if ((t % 16) == 15) checkOutput("rate0", rate0, rate_tab[w]);
            checkOutput("rate_valid1", rate_valid1, (t % 1024) == 1023);
            if ((t % 1024) == 1023) checkOutput("rate1_sat", rate1, 255);
        end else begin
            t = -1;
            checkOutput("reset_outs0", {spike0, rate0, rate_valid0, isi0, isi_valid0}, 0);
            checkOutput("reset_outs1", {spike1, rate1, rate_valid1, isi1, isi_valid1}, 0);
        end
`ifndef QIF_DECODER_ISI_EN
        checkOutput("isi_off", {isi0, isi_valid0, isi1, isi_valid1}, 0);
`endif
    endtask

    task automatic holdUntil(input logic [7:0] v, input int last);
        while (t < last) applyStimulus(v);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        t          = -1;
        rate_tab   = '{1, 1, 3, 3, 1};

        // Reset with the voltage pinned high.
        rst_n = 1'b0;
        applyStimulus(8'd255);
        applyStimulus(8'd255);
        rst_n = 1'b1;

        // High voltage out of reset must not fire while in INIT.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'd255);
            checkOutput("init_quiet", spike0, 0);
        end
        applyStimulus(8'd100);
        checkOutput("armed_no_spike", spike0, 0);
        applyStimulus(8'd200);
        checkOutput("first_spike", spike0, 1);
`ifdef QIF_DECODER_ISI_EN
        checkOutput("first_isi_valid", isi_valid0, 0);
`endif
        applyStimulus(8'd200);
        checkOutput("spike_one_cycle", spike0, 0);

        // Chatter above the rearm level stays silent.
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 8'd190 : 8'd200);
            checkOutput("chatter", spike0, 0);
        end
        applyStimulus(8'd184);
        checkOutput("rearm_184", spike0, 0);
        applyStimulus(8'd200);
        checkOutput("second_spike", spike0, 1);
`ifdef QIF_DECODER_ISI_EN
        checkOutput("isi0_13", isi0, 13);
        checkOutput("isi0_13_valid", isi_valid0, 1);
        checkOutput("isi1_13", isi1, 13);
`endif
        holdUntil(8'd0, 31);

        // Two windows with three spikes each, the last in the terminal cycle.
        for (int k = 0; k < 2; k++) begin
            for (int o = 0; o < 16; o++) begin
                applyStimulus((o == 1 || o == 3 || o == 14) ? 8'd255 : 8'd0);
            end
        end
`ifdef QIF_DECODER_ISI_EN
        checkOutput("isi0_11", isi0, 11);
        checkOutput("isi0_idle_valid", isi_valid0, 0);
`endif

        // Window whose only spike sits in the terminal cycle.
        holdUntil(8'd0, 77);
        applyStimulus(8'd255);
        checkOutput("terminal_spike", spike0, 1);
        applyStimulus(8'd0);
        applyStimulus(8'd0);
        applyStimulus(8'd255);
        checkOutput("pending_spike", spike0, 1);
        checkOutput("rate_held", rate0, 1);
`ifdef QIF_DECODER_ISI_EN
        checkOutput("isi0_3", isi0, 3);
`endif

        // One-cycle reset mid-window with a spike in flight.
        rst_n = 1'b0;
        rate_tab = '{0, 1, 0, 3, 8};
        applyStimulus(8'd0);
        rst_n = 1'b1;

        holdUntil(8'd0, 19);
        applyStimulus(8'd255);
        checkOutput("post_rst_spike", spike0, 1);
`ifdef QIF_DECODER_ISI_EN
        checkOutput("post_rst_no_isi", isi_valid0, 0);
`endif
        applyStimulus(8'd0);
        checkOutput("post_rst_single", spike0, 0);
        holdUntil(8'd0, 56);
        applyStimulus(8'd255);
        checkOutput("isi_pair_spike", spike0, 1);
`ifdef QIF_DECODER_ISI_EN
        checkOutput("isi0_37", isi0, 37);
        checkOutput("isi0_37_valid", isi_valid0, 1);
        checkOutput("isi1_sat", isi1, 15);
        checkOutput("isi1_sat_valid", isi_valid1, 1);
`endif

        // Alternate 0/255 every cycle: 8 spikes per short window, saturated long window.
        while (t < 2047) applyStimulus(((t + 1) % 2 == 1) ? 8'd255 : 8'd0);
        checkOutput("alt_rate0", rate0, 8);
        checkOutput("alt_rate1", rate1, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
